grid_mem_arbiter: RTL

- Shares the single-port snake-game grid RAM (one cell per tile: empty/snake/food/wall) between two requesters.
  - The display pixel fetcher reads cells while drawing.
  - The game logic reads and writes cells on each move.
- After reset, sequences a full RAM clear before normal arbitration starts.
- Sits between the LCD timing/render path and the game FSM, inside the LCD top level.

---
 rtl/grid_mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/grid_mem_arbiter.sv
`default_nettype none
// ============================================================================
// grid_mem_arbiter - clears the grid RAM after reset, then shares its single
// port between display reads and game reads/writes. Option: STARVE_GUARD_EN
// Revision: 1.0
// ============================================================================
module grid_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 768,
  parameter int DATA_W     = 2,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  output logic              disp_miss,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic [DATA_W-1:0] game_rdata,
  output logic              game_rvalid,
  output logic              init_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || STARVE_MAX < 1) begin : g_bad_cfg
    $error("grid_mem_arbiter: illegal DEPTH/ADDR_W/STARVE_MAX combination");
  end

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic                mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                gnt_d, gnt_q, miss_d, miss_q;
  logic                p1_vld_d, p1_game_d, p1_zero_d;
  logic                p1_vld_q, p1_game_q, p1_zero_q;
  logic                p2_vld_q, p2_game_q, p2_zero_q;
  logic                disp_valid_q, game_rvalid_q, init_done_q;
  logic [DATA_W-1:0]   disp_rdata_q, game_rdata_q;
  logic                w_force;

`ifdef STARVE_GUARD_EN
  localparam int C_STARVE_W = $clog2(STARVE_MAX + 1);
  logic [C_STARVE_W-1:0] starve_q, starve_d;

  assign w_force = (starve_q == C_STARVE_W'(STARVE_MAX)) && game_req && !gnt_q;

  always_comb begin
    starve_d = starve_q;
    if (gnt_q)
      starve_d = '0;
    else if (state_q == ST_RUN && game_req && disp_req && !w_force)
      starve_d = starve_q + C_STARVE_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    gnt_d       = 1'b0;
    miss_d      = 1'b0;
    p1_vld_d    = 1'b0;
    p1_game_d   = 1'b0;
    p1_zero_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = clr_q;
        clr_d      = clr_q + ADDR_W'(1);
        if (clr_q == C_LAST_ADDR) state_d = ST_RUN;
        // Display reads during the sweep are answered with an empty cell.
        p1_vld_d  = disp_req;
        p1_zero_d = disp_req;
      end
      ST_RUN: begin
        if (game_req && !gnt_q && (!disp_req || w_force)) begin
          gnt_d       = 1'b1;
          miss_d      = disp_req;
          mem_en_d    = 1'b1;
          mem_we_d    = game_we;
          mem_addr_d  = game_addr;
          mem_wdata_d = game_wdata;
          p1_vld_d    = !game_we;
          p1_game_d   = 1'b1;
        end else if (disp_req) begin
          mem_en_d   = 1'b1;
          mem_addr_d = disp_addr;
          p1_vld_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      gnt_q         <= 1'b0;
      miss_q        <= 1'b0;
      p1_vld_q      <= 1'b0;
      p1_game_q     <= 1'b0;
      p1_zero_q     <= 1'b0;
      p2_vld_q      <= 1'b0;
      p2_game_q     <= 1'b0;
      p2_zero_q     <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_rdata_q  <= '0;
      game_rvalid_q <= 1'b0;
      game_rdata_q  <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      gnt_q         <= gnt_d;
      miss_q        <= miss_d;
      p1_vld_q      <= p1_vld_d;
      p1_game_q     <= p1_game_d;
      p1_zero_q     <= p1_zero_d;
      p2_vld_q      <= p1_vld_q;
      p2_game_q     <= p1_game_q;
      p2_zero_q     <= p1_zero_q;
      // The owner tag travels with the read so data returns to its requester.
      disp_valid_q  <= p2_vld_q && !p2_game_q;
      game_rvalid_q <= p2_vld_q && p2_game_q;
      if (p2_vld_q && !p2_game_q) disp_rdata_q <= p2_zero_q ? '0 : mem_rdata;
      if (p2_vld_q && p2_game_q)  game_rdata_q <= mem_rdata;
      init_done_q   <= init_done_q || (state_q == ST_RUN);
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign game_gnt    = gnt_q;
  assign disp_miss   = miss_q;
  assign disp_valid  = disp_valid_q;
  assign disp_rdata  = disp_rdata_q;
  assign game_rvalid = game_rvalid_q;
  assign game_rdata  = game_rdata_q;
  assign init_done   = init_done_q;

endmodule
`default_nettype wire
